// File: rtl/cclk_pkg.sv
// Shared types and constants for divided-clock consumers.
package cclk_pkg;

  typedef enum logic [2:0] {
    CTM_IDLE    = 3'd0,
    CTM_ACQUIRE = 3'd1,
    CTM_MEASURE = 3'd2,
    CTM_LOCKED  = 3'd3,
    CTM_STALL   = 3'd4
  } ctm_state_e;

  localparam int unsigned CTM_TIMEOUT_DEFAULT = 65535;

endpackage

// File: rtl/sync_edge_det.sv
// Synchroniser chain plus a history flop for edge detection on a slow,
// asynchronous level; rise_o/fall_o are true for the cycle an edge is seen.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] s;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      s    <= '0;
      prev <= 1'b0;
    end else begin
      s    <= {s[SYNC_STAGES-2:0], d_i};
      prev <= s[SYNC_STAGES-1];
    end
  end

  assign rise_o = s[SYNC_STAGES-1] & ~prev;
  assign fall_o = ~s[SYNC_STAGES-1] & prev;

endmodule

// File: rtl/cclk_tick_meter.sv
// Turns a divided clock into clk-domain rise/fall enables, measures its
// rise-to-rise period and flags it when it stops toggling.
module cclk_tick_meter
  import cclk_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PERIOD_W    = 16,
  parameter int TIMEOUT     = CTM_TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                slow_clk_i,
  output logic                tick_rise,
  output logic                tick_fall,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                stalled
);

  localparam logic [PERIOD_W-1:0] TIMEOUT_CNT = PERIOD_W'(TIMEOUT);

  logic                rise;
  logic                fall;
  logic [PERIOD_W-1:0] cnt;
  logic                timed_out;
  ctm_state_e          state;
  ctm_state_e          state_nxt;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (slow_clk_i),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign timed_out = (cnt == TIMEOUT_CNT);

  // A rise in the same cycle as the timeout takes priority.
  always_comb begin
    state_nxt = state;
    case (state)
      CTM_IDLE:    if (en) state_nxt = CTM_ACQUIRE;
      CTM_ACQUIRE: if (rise) state_nxt = CTM_MEASURE;
                   else if (timed_out) state_nxt = CTM_STALL;
      CTM_MEASURE: if (rise) state_nxt = CTM_LOCKED;
                   else if (timed_out) state_nxt = CTM_STALL;
      CTM_LOCKED:  if (!rise && timed_out) state_nxt = CTM_STALL;
      CTM_STALL:   if (rise) state_nxt = CTM_MEASURE;
      default:     state_nxt = CTM_IDLE;
    endcase
    if (!en) state_nxt = CTM_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= CTM_IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
      tick_rise    <= 1'b0;
      tick_fall    <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick_rise <= en & rise;
      tick_fall <= en & fall;

      if (!en)              cnt <= '0;
      else if (rise)        cnt <= PERIOD_W'(1);
      else if (cnt != '1)   cnt <= cnt + 1'b1;

      if (en && rise && (state == CTM_MEASURE || state == CTM_LOCKED))
        period <= cnt;

      // Status flags follow the state being entered.
      period_valid <= (state_nxt == CTM_LOCKED);
      stalled      <= (state_nxt == CTM_STALL);
    end
  end

endmodule

// File: tb/tb_cclk_tick_meter.sv
// Directed bench for cclk_tick_meter: lock, period change, stall, enable and reset.
module tb_cclk_tick_meter;
  import cclk_pkg::*;

  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          slow_clk_i;
  logic          tick_rise;
  logic          tick_fall;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          stalled;

  int n_checks = 0;
  int n_fail   = 0;

  cclk_tick_meter #(.SYNC_STAGES(2), .PERIOD_W(PW), .TIMEOUT(20)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .slow_clk_i   (slow_clk_i),
    .tick_rise    (tick_rise),
    .tick_fall    (tick_fall),
    .period       (period),
    .period_valid (period_valid),
    .stalled      (stalled)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the edge; new inputs land there too.
  task automatic tick_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic slow_cycles(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      slow_clk_i = 1'b1;
      tick_clk(hi);
      slow_clk_i = 1'b0;
      tick_clk(lo);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".tick_rise"}, 32'(tick_rise), 0);
    chk({tag, ".tick_fall"}, 32'(tick_fall), 0);
    chk({tag, ".period"}, 32'(period), 0);
    chk({tag, ".period_valid"}, 32'(period_valid), 0);
    chk({tag, ".stalled"}, 32'(stalled), 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; slow_clk_i = 1'b0;

    // 1: reset
    tick_clk(3);
    chk_all_zero("rst");
    rst = 1'b0;
    tick_clk(1);
    chk_all_zero("post_rst");
    chk("post_rst.state", 32'(dut.state), 32'(CTM_ACQUIRE));

    // 2: div2-style input, period 4; rise first sampled at edge k ticks after edge k+2
    for (int i = 0; i < 12; i++) begin
      slow_clk_i = ((i / 2) % 2) == 0;
      tick_clk(1);
      chk($sformatf("div2.rise%0d", i), 32'(tick_rise), 32'(i >= 2 && (i - 2) % 4 == 0));
      chk($sformatf("div2.fall%0d", i), 32'(tick_fall), 32'(i >= 4 && i % 4 == 0));
      if (i == 6) begin
        chk("div2.period", 32'(period), 4);
        chk("div2.valid", 32'(period_valid), 1);
      end
    end

    // 3: period 8, then 12
    slow_cycles(4, 4, 3);
    chk("p8.period", 32'(period), 8);
    chk("p8.valid", 32'(period_valid), 1);
    slow_cycles(6, 6, 1);
    chk("p12a.period", 32'(period), 8);
    slow_cycles(6, 6, 1);
    chk("p12.period", 32'(period), 12);
    chk("p12.valid", 32'(period_valid), 1);

    // 4: held high -> stall 20 cycles after the last rise tick
    slow_clk_i = 1'b1;
    tick_clk(3);
    chk("hold.tick", 32'(tick_rise), 1);
    tick_clk(19);
    chk("stall_m1.stalled", 32'(stalled), 0);
    chk("stall_m1.valid", 32'(period_valid), 1);
    tick_clk(1);
    chk("stall.stalled", 32'(stalled), 1);
    chk("stall.valid", 32'(period_valid), 0);
    chk("stall.period", 32'(period), 12);
    slow_clk_i = 1'b0;
    tick_clk(3);
    slow_clk_i = 1'b1;
    tick_clk(3);
    chk("recover.tick", 32'(tick_rise), 1);
    chk("recover.stalled", 32'(stalled), 0);
    chk("recover.valid", 32'(period_valid), 0);
    tick_clk(3);
    slow_clk_i = 1'b0;
    tick_clk(4);
    slow_clk_i = 1'b1;
    tick_clk(2);
    chk("relock_m1.valid", 32'(period_valid), 0);
    tick_clk(1);
    chk("relock.valid", 32'(period_valid), 1);
    chk("relock.period", 32'(period), 10);

    // 5: enable dropped for 5 cycles while locked
    en = 1'b0;
    for (int j = 0; j < 5; j++) begin
      slow_clk_i = (j == 0);
      tick_clk(1);
      chk($sformatf("en_off%0d.rise", j), 32'(tick_rise), 0);
      chk($sformatf("en_off%0d.fall", j), 32'(tick_fall), 0);
      chk($sformatf("en_off%0d.valid", j), 32'(period_valid), 0);
      chk($sformatf("en_off%0d.period", j), 32'(period), 10);
    end
    en = 1'b1;
    tick_clk(1);
    chk("en_on.state", 32'(dut.state), 32'(CTM_ACQUIRE));
    chk("en_on.fall", 32'(tick_fall), 0);
    // no rise while acquiring -> stall after TIMEOUT counts
    tick_clk(19);
    chk("acq_m1.stalled", 32'(stalled), 0);
    tick_clk(1);
    chk("acq.stalled", 32'(stalled), 1);
    slow_cycles(4, 4, 2);
    chk("acq_lock.period", 32'(period), 8);
    chk("acq_lock.valid", 32'(period_valid), 1);
    chk("acq_lock.stalled", 32'(stalled), 0);

    // rise coincides with cnt == TIMEOUT: rise wins
    slow_cycles(10, 10, 2);
    chk("p20.period", 32'(period), 20);
    chk("p20.valid", 32'(period_valid), 1);
    chk("p20.stalled", 32'(stalled), 0);

    // 6: reset with a rise in the sync chain
    slow_clk_i = 1'b1;
    tick_clk(2);
    rst = 1'b1;
    tick_clk(1);
    chk_all_zero("mid_rst");
    rst = 1'b0;
    tick_clk(1);
    chk("mid_rst1.tick_rise", 32'(tick_rise), 0);
    chk("mid_rst1.period", 32'(period), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
